// File: rtl/ysyx_24080014_mem_rd_arbiter.sv
// ysyx_24080014_mem_rd_arbiter: IFU (m0) / LSU (m1) arbiter for one memory read port, with a response watchdog.
// Define YSYX_24080014_RR_ARB_EN for round-robin arbitration; otherwise m1 has fixed priority over m0.
module ysyx_24080014_mem_rd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_e;
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  state_e state_q;
  logic own_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WD_W-1:0] wd_q;
  logic win, own_rready, in_data, in_err;
`ifdef YSYX_24080014_RR_ARB_EN
  logic last_q;
  assign win = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
`else
  assign win = m1_arvalid;
`endif
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
`ifdef YSYX_24080014_RR_ARB_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (m0_arvalid || m1_arvalid) begin
          state_q <= ADDR;
          own_q   <= win;
          addr_q  <= win ? m1_araddr : m0_araddr;
`ifdef YSYX_24080014_RR_ARB_EN
          last_q  <= win;
`endif
        end
        ADDR: if (s_arready) begin
          state_q <= DATA;
          wd_q    <= '0;
        end
        DATA: if (s_rvalid && s_rready) state_q <= IDLE;
          else if (!s_rvalid) begin
            if (wd_q == WD_MAX) state_q <= ERR;
            else wd_q <= wd_q + 1'b1;
          end
        ERR: if (own_rready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_data    = state_q == DATA;
  assign in_err     = state_q == ERR;
  assign own_rready = own_q ? m1_rready : m0_rready;
  assign m0_arready = state_q == IDLE && m0_arvalid && !win;
  assign m1_arready = state_q == IDLE && m1_arvalid && win;
  assign s_araddr   = addr_q;
  assign s_arvalid  = state_q == ADDR;
  assign s_rready   = in_data && own_rready;
  assign grant      = state_q == IDLE ? 2'b00 : {own_q, !own_q};
  // A timed-out transaction answers its owner with a zero SLVERR beat.
  assign m0_rvalid  = !own_q && ((in_data && s_rvalid) || in_err);
  assign m0_rdata   = (!own_q && in_data) ? s_rdata : '0;
  assign m0_rresp   = !own_q ? (in_data ? s_rresp : {in_err, 1'b0}) : 2'b00;
  assign m1_rvalid  = own_q && ((in_data && s_rvalid) || in_err);
  assign m1_rdata   = (own_q && in_data) ? s_rdata : '0;
  assign m1_rresp   = own_q ? (in_data ? s_rresp : {in_err, 1'b0}) : 2'b00;
endmodule

// File: tb/tb_ysyx_24080014_mem_rd_arbiter.sv
// tb_ysyx_24080014_mem_rd_arbiter: directed and random checks of the read arbiter against a transaction-level model.
module tb_ysyx_24080014_mem_rd_arbiter;
  localparam int TO = 16;
  typedef struct {logic [31:0] d; logic [1:0] r; logic h;} exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic arv[2], rr[2], ardy[2], rv[2], pending[2];
  logic [31:0] ara[2], rd[2];
  logic [1:0] rs[2], grant;
  logic [31:0] s_araddr, s_rdata = 0;
  logic s_arvalid, s_arready = 0, s_rvalid = 0, s_rready;
  logic [1:0] s_rresp = 0;
  int total = 0, bad = 0;
  ysyx_24080014_mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .ACLK(clk), .ARESET(rst),
    .m0_araddr(ara[0]), .m0_arvalid(arv[0]), .m0_arready(ardy[0]), .m0_rdata(rd[0]),
    .m0_rresp(rs[0]), .m0_rvalid(rv[0]), .m0_rready(rr[0]),
    .m1_araddr(ara[1]), .m1_arvalid(arv[1]), .m1_arready(ardy[1]), .m1_rdata(rd[1]),
    .m1_rresp(rs[1]), .m1_rvalid(rv[1]), .m1_rready(rr[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready), .grant(grant));

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a - 32'h8000_0000) * 3 + 32'h413;
  endfunction
  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return a[3:2] == 2'b11 ? 2'b10 : 2'b00;
  endfunction
  function automatic logic hang(input logic [31:0] a);
    return a[11:4] == 8'hEE;
  endfunction
  function automatic logic [31:0] gen_addr();
    logic [31:0] a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 15) == 0) a[11:4] = 8'hEE;
    else if (a[11:4] == 8'hEE) a[11:4] = 8'h11;
    return a;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wait_until(input int w, input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((w == 0 && ardy[0]) || (w == 1 && ardy[1]) || (w == 2 && rv[0]) || (w == 3 && rv[1]) ||
          (w == 4 && (ardy[0] || ardy[1]))) return;
    end
    total++; bad++;
    $display("FAIL %s: event never arrived within 60 cycles", nm);
  endtask

  // Memory slave model: samples handshakes at negedge, drives just after posedge.
  logic fast = 1, rst_s, ar_hs, r_hs, sl_busy = 0;
  logic [31:0] sa, sl_addr;
  int sl_cnt, rdl = 0, ar_low = 0;
  always begin
    @(negedge clk);
    ar_hs = s_arvalid && s_arready; r_hs = s_rvalid && s_rready; sa = s_araddr; rst_s = rst;
    @(posedge clk); #1;
    if (rst_s) begin
      s_rvalid = 0; s_rdata = 0; s_rresp = 0; sl_busy = 0;
    end else begin
      if (r_hs) begin s_rvalid = 0; s_rdata = 0; s_rresp = 0; end
      if (ar_hs) begin sl_busy = !hang(sa); sl_addr = sa; sl_cnt = fast ? rdl : $urandom_range(0, 4); end
      if (sl_busy && !s_rvalid) begin
        if (sl_cnt == 0) begin
          s_rvalid = 1; s_rdata = mem_data(sl_addr); s_rresp = mem_resp(sl_addr); sl_busy = 0;
        end else sl_cnt--;
      end
    end
    s_arready = ar_low > 0 ? 1'b0 : fast ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (ar_low > 0) ar_low--;
  end

  // Random master driver.
  logic rand_on = 0;
  always @(posedge clk) if (rand_on) begin
    #1;
    for (int n = 0; n < 2; n++) begin
      if (pending[n]) begin
        arv[n] = 0;
        if ($urandom_range(0, 1) == 1) ara[n] = $urandom;
      end else if (!arv[n] && $urandom_range(0, 2) == 0) begin
        arv[n] = 1; ara[n] = gen_addr();
      end
      rr[n] = $urandom_range(0, 3) != 0;
    end
  end

  // Monitor / scoreboard: one transaction at a time, judged from the protocol rules.
  exp_t q[2][$];
  exp_t e;
  logic mon_on = 0, busy = 0, own = 0, ar_done = 0, cur_hang = 0, first = 0, last_tb = 1, e0, e1, pick1;
  logic [31:0] cur_addr = 0;
  int tcnt = 0;
  always @(negedge clk) if (mon_on) begin
    tcnt++;
    chk("grant", grant, busy ? (own ? 2'b10 : 2'b01) : 2'b00);
    chk("s_arvalid", s_arvalid, busy && !ar_done);
    if (s_arvalid) chk("s_araddr", s_araddr, cur_addr);
    chk("s_rready", s_rready, busy && ar_done && !(cur_hang && tcnt > TO) && rr[own]);
`ifdef YSYX_24080014_RR_ARB_EN
    pick1 = !last_tb;
`else
    pick1 = 1;
`endif
    e1 = !busy && arv[1] && (!arv[0] || pick1);
    e0 = !busy && arv[0] && !e1;
    chk("m0_arready", ardy[0], e0);
    chk("m1_arready", ardy[1], e1);
    for (int n = 0; n < 2; n++) begin
      if (busy && own == n) begin
        if (rv[n]) begin
          if (q[n].size() == 0) chk("unexpected_beat", rv[n], 0);
          else begin
            chk("rdata", rd[n], q[n][0].d);
            chk("rresp", rs[n], q[n][0].r);
            if (first && q[n][0].h) chk("timeout_latency", tcnt, TO + 1);
          end
          first = 0;
        end
      end else chk("non_owner_quiet", {rv[n], rd[n], rs[n]}, 0);
    end
    if (rst) begin
      busy = 0; ar_done = 0; cur_hang = 0; last_tb = 1; pending[0] = 0; pending[1] = 0;
      q[0].delete(); q[1].delete();
    end else begin
      if (busy && rv[own] && rr[own]) begin
        if (q[own].size() != 0) void'(q[own].pop_front());
        busy = 0; pending[own] = 0;
      end
      if (s_arvalid && s_arready) begin tcnt = 0; ar_done = 1; end
      if (e0 || e1) begin
        busy = 1; ar_done = 0; first = 1; own = e1; last_tb = e1; pending[e1] = 1;
        cur_addr = ara[e1]; cur_hang = hang(cur_addr);
        e.h = cur_hang; e.d = cur_hang ? 32'h0 : mem_data(cur_addr);
        e.r = cur_hang ? 2'b10 : mem_resp(cur_addr);
        q[e1].push_back(e);
      end
    end
  end

  initial begin
    for (int n = 0; n < 2; n++) begin arv[n] = 0; ara[n] = 0; rr[n] = 0; pending[n] = 0; end
    tick; mon_on = 1;
    tick;
    @(negedge clk);
    chk("rst_data", {rd[0], rd[1]}, 0);
    chk("rst_ctl", {ardy[0], ardy[1], rv[0], rv[1], rs[0], rs[1], s_arvalid, s_rready, grant}, 0);
    chk("rst_addr", s_araddr, 0);
    tick; rst = 0;
    tick;
    // m0 alone, cycle-exact latency
    arv[0] = 1; ara[0] = 32'h8000_0000; rr[0] = 1; rr[1] = 1;
    @(negedge clk); chk("lat_arready_c0", ardy[0], 1);
    tick; arv[0] = 0;
    @(negedge clk); chk("lat_s_arvalid_c1", s_arvalid, 1); chk("lat_s_araddr_c1", s_araddr, 32'h8000_0000);
    tick;
    @(negedge clk); chk("lat_rvalid_c2", rv[0], 1); chk("lat_rdata_c2", rd[0], 32'h0000_0413);
    chk("lat_grant_c2", grant, 2'b01);
    tick;
    @(negedge clk); chk("lat_grant_idle", grant, 2'b00);
    tick;
    // simultaneous requests: m1 wins, m0 waits
    arv[0] = 1; ara[0] = 32'h8000_0004; arv[1] = 1; ara[1] = 32'h8000_1000;
    @(negedge clk); chk("both_m1_wins", ardy[1], 1); chk("both_m0_waits", ardy[0], 0);
    tick; arv[1] = 0;
    wait_until(0, "m0_second_grant");
    tick; arv[0] = 0;
    @(negedge clk); chk("m0_second_grant", grant, 2'b01);
    wait_until(2, "m0_second_beat");
    tick;
    // backpressure on both address and data phases
    @(negedge clk); ar_low = 4;
    tick; arv[0] = 1; ara[0] = 32'h8000_0040; rr[0] = 0;
    tick; arv[0] = 0; ara[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("bp_s_arvalid", s_arvalid, 1); chk("bp_s_araddr", s_araddr, 32'h8000_0040);
    end
    wait_until(2, "bp_beat");
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_s_rready", s_rready, 0); chk("bp_hold_rvalid", rv[0], 1);
      chk("bp_hold_rdata", rd[0], mem_data(32'h8000_0040));
    end
    tick; rr[0] = 1;
    @(negedge clk); chk("bp_release", s_rready, 1);
    tick;
    // watchdog: slave never answers
    arv[0] = 1; ara[0] = 32'h8000_0EE0;
    tick; arv[0] = 0;
    wait_until(2, "timeout_beat");
    chk("timeout_rdata", rd[0], 0); chk("timeout_rresp", rs[0], 2'b10);
    tick; arv[0] = 1; ara[0] = 32'h8000_0100;
    tick; arv[0] = 0;
    wait_until(2, "after_timeout_beat");
    chk("after_timeout_rdata", rd[0], mem_data(32'h8000_0100));
    tick;
    // reset pulse while in DATA
    @(negedge clk); rdl = 5;
    tick; arv[1] = 1; ara[1] = 32'h8000_2000;
    tick; arv[1] = 0;
    tick; rst = 1;
    tick; rst = 0;
    @(negedge clk);
    chk("midrst_ctl", {ardy[0], ardy[1], rv[0], rv[1], rs[0], rs[1], s_arvalid, s_rready, grant}, 0);
    chk("midrst_data", {rd[0], rd[1]}, 0);
    rdl = 0;
    tick; arv[1] = 1; ara[1] = 32'h8000_3000;
    tick; arv[1] = 0;
    wait_until(3, "post_reset_beat");
    chk("post_reset_rdata", rd[1], mem_data(32'h8000_3000));
    tick;
    // continuous requests from both masters
    arv[0] = 1; ara[0] = 32'h8000_0200; arv[1] = 1; ara[1] = 32'h8000_0300;
    for (int i = 0; i < 4; i++) begin
      wait_until(4, "contend_grant");
`ifdef YSYX_24080014_RR_ARB_EN
      chk("contend_winner_m1", ardy[1], i % 2);
`else
      chk("contend_winner_m1", ardy[1], 1);
`endif
    end
    tick; arv[0] = 0; arv[1] = 0;
    repeat (20) tick;
    // random traffic
    @(negedge clk); fast = 0; rand_on = 1;
    repeat (3000) @(posedge clk);
    @(negedge clk); rand_on = 0;
    tick; arv[0] = 0; arv[1] = 0; rr[0] = 1; rr[1] = 1;
    repeat (60) tick;
    @(negedge clk); chk("drain_outstanding", q[0].size() + q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
